// File: rtl/nonce_search_if.sv
// rtl/nonce_search_if.sv - hash core / checker handshake bundle for the nonce sweep
interface nonce_search_if #(
    parameter int NONCE_W = 32
);
    logic               hash_start;
    logic [NONCE_W-1:0] nonce;
    logic               hash_done;
    logic               check_hash;
    logic               valid_hash;

    modport master (
        output hash_start,
        output nonce,
        output check_hash,
        input  hash_done,
        input  valid_hash
    );

    modport slave (
        input  hash_start,
        input  nonce,
        input  check_hash,
        output hash_done,
        output valid_hash
    );
endinterface

// File: rtl/nonce_search_ctrl.sv
// rtl/nonce_search_ctrl.sv - sweeps an inclusive nonce range, one hash per nonce,
// stopping on first pass, range exhaustion or hash-core timeout
module nonce_search_ctrl #(
    parameter int NONCE_W = 32,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] start_nonce,
    input  logic [NONCE_W-1:0] end_nonce,
    nonce_search_if.master     hif,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               error,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [CNT_W-1:0]   attempts
);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FOUND, S_EXHAUST, S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] end_q, end_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic [CNT_W-1:0]   attempts_q, attempts_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic hash_start_q, hash_start_d;
    logic check_hash_q, check_hash_d;
    logic busy_q, busy_d;
    logic found_q, found_d;
    logic exhausted_q, exhausted_d;
    logic error_q, error_d;

    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        end_d         = end_q;
        found_nonce_d = found_nonce_q;
        attempts_d    = attempts_q;
        timer_d       = timer_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FOUND, S_EXHAUST, S_ERROR: begin
                    if (start) begin
                        nonce_d       = start_nonce;
                        end_d         = end_nonce;
                        attempts_d    = '0;
                        found_nonce_d = '0;
                        state_d       = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (hif.hash_done) begin
                        state_d = S_CHECK;
                    end else if (timer_q == TMR_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    attempts_d = (&attempts_q) ? attempts_q : attempts_q + CNT_W'(1);
                    // A pass on the final nonce must win over exhaustion.
                    if (hif.valid_hash) begin
                        found_nonce_d = nonce_q;
                        state_d       = S_FOUND;
                    end else if (nonce_q == end_q) begin
                        state_d = S_EXHAUST;
                    end else begin
                        nonce_d = nonce_q + NONCE_W'(1);
                        state_d = S_ISSUE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered as a decode of the next state.
        hash_start_d = (state_d == S_ISSUE);
        check_hash_d = (state_d == S_CHECK);
        busy_d       = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CHECK);
        found_d      = (state_d == S_FOUND);
        exhausted_d  = (state_d == S_EXHAUST);
        error_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            nonce_q       <= '0;
            end_q         <= '0;
            found_nonce_q <= '0;
            attempts_q    <= '0;
            timer_q       <= '0;
            hash_start_q  <= 1'b0;
            check_hash_q  <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            end_q         <= end_d;
            found_nonce_q <= found_nonce_d;
            attempts_q    <= attempts_d;
            timer_q       <= timer_d;
            hash_start_q  <= hash_start_d;
            check_hash_q  <= check_hash_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            error_q       <= error_d;
        end
    end

    assign hif.hash_start = hash_start_q;
    assign hif.nonce      = nonce_q;
    assign hif.check_hash = check_hash_q;
    assign busy           = busy_q;
    assign found          = found_q;
    assign exhausted      = exhausted_q;
    assign error          = error_q;
    assign found_nonce    = found_nonce_q;
    assign attempts       = attempts_q;
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// tb/tb_nonce_search_ctrl.sv - scoreboard bench for nonce_search_ctrl
module tb_nonce_search_ctrl;
    localparam int NW = 32;
    localparam int CW = 32;
    localparam int DONE_DLY = 3;

    localparam int K_HS  = 0;
    localparam int K_CK  = 1;
    localparam int K_END = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
        logic [2:0]  flags;
        logic [31:0] att;
    } ev_t;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic          abort;
    logic [NW-1:0] start_nonce;
    logic [NW-1:0] end_nonce;
    logic          busy, found, exhausted, error;
    logic [NW-1:0] found_nonce;
    logic [CW-1:0] attempts;

    logic          core_done;
    logic          late_done;
    logic          withhold;
    logic          pass_en;
    logic [NW-1:0] pass_nonce;

    int passed;
    int total;
    ev_t q[$];

    nonce_search_if #(.NONCE_W(NW)) hif ();

    assign hif.hash_done  = core_done | late_done;
    assign hif.valid_hash = pass_en && (hif.nonce == pass_nonce);

    nonce_search_ctrl #(.NONCE_W(NW), .TIMEOUT(256), .CNT_W(CW)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .abort       (abort),
        .start_nonce (start_nonce),
        .end_nonce   (end_nonce),
        .hif         (hif.master),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .error       (error),
        .found_nonce (found_nonce),
        .attempts    (attempts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic exp_hs(input logic [31:0] n);
        ev_t e;
        e.kind = K_HS; e.val = n; e.flags = 3'b000; e.att = 0;
        q.push_back(e);
    endtask

    task automatic exp_nonce(input logic [31:0] n);
        ev_t e;
        exp_hs(n);
        e.kind = K_CK; e.val = n; e.flags = 3'b000; e.att = 0;
        q.push_back(e);
    endtask

    task automatic exp_end(input logic [2:0] flags, input logic [31:0] fn, input logic [31:0] att);
        ev_t e;
        e.kind = K_END; e.val = fn; e.flags = flags; e.att = att;
        q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [31:0] val,
                        input logic [2:0] flags, input logic [31:0] att);
        ev_t e;
        if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: got kind %0d value %0h expected no event", kind, val);
        end else begin
            e = q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("event_value", 64'(val), 64'(e.val));
            if (e.kind == K_END && kind == K_END) begin
                chk("end_flags", 64'(flags), 64'(e.flags));
                chk("end_attempts", 64'(att), 64'(e.att));
            end
        end
    endtask

    // Monitor: every hash_start, check_hash and end-of-sweep is matched against the queue.
    initial begin
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_busy = 1'b0;
            end else begin
                if (hif.hash_start) take(K_HS, hif.nonce, 3'b000, 32'd0);
                if (hif.check_hash) take(K_CK, hif.nonce, 3'b000, 32'd0);
                if (prev_busy && !busy) take(K_END, found_nonce, {found, exhausted, error}, attempts);
                prev_busy = busy;
            end
        end
    end

    // Hash core model: answers each hash_start after a fixed delay unless withheld.
    initial begin
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (hif.hash_start && !withhold) begin
                repeat (DONE_DLY) @(negedge clk);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    task automatic launch(input logic [31:0] s, input logic [31:0] e);
        @(negedge clk);
        start = 1'b1; start_nonce = s; end_nonce = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            $display("FAIL %s_timeout: got busy=1 expected sweep to end within 2000 cycles", name);
        end
        @(negedge clk);
    endtask

    task automatic wait_hs(input string name);
        int n;
        n = 0;
        while (!hif.hash_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!hif.hash_start) begin
            total++;
            $display("FAIL %s_no_hash_start: got 0 expected hash_start within 100 cycles", name);
        end
    endtask

    initial begin
        int cnt;
        passed = 0; total = 0;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        start_nonce = '0; end_nonce = '0;
        withhold = 1'b0; late_done = 1'b0; pass_en = 1'b0; pass_nonce = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_flags", 64'({found, exhausted, error}), 64'd0);
        chk("reset_strobes", 64'({hif.hash_start, hif.check_hash}), 64'd0);
        chk("reset_nonce", 64'(hif.nonce), 64'd0);
        chk("reset_attempts", 64'(attempts), 64'd0);
        chk("reset_found_nonce", 64'(found_nonce), 64'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // T1: pass on the third of four nonces
        pass_en = 1'b1; pass_nonce = 32'd12;
        exp_nonce(32'd10); exp_nonce(32'd11); exp_nonce(32'd12);
        exp_end(3'b100, 32'd12, 32'd3);
        launch(32'd10, 32'd13);
        wait_end("t1");
        repeat (5) @(negedge clk);
        chk("t1_found_held", 64'(found), 64'd1);
        chk("t1_found_nonce_held", 64'(found_nonce), 64'd12);

        // T2: exhaustion; a start while busy must be ignored
        pass_en = 1'b0;
        exp_nonce(32'd5); exp_nonce(32'd6); exp_nonce(32'd7);
        exp_end(3'b010, 32'd0, 32'd3);
        launch(32'd5, 32'd7);
        repeat (2) @(negedge clk);
        start = 1'b1; start_nonce = 32'h100; end_nonce = 32'h200;
        @(negedge clk);
        start = 1'b0;
        wait_end("t2");
        repeat (4) @(negedge clk);
        chk("t2_exhausted_held", 64'(exhausted), 64'd1);

        // T3: range wraps through zero
        exp_nonce(32'hFFFF_FFFE); exp_nonce(32'hFFFF_FFFF);
        exp_nonce(32'h0); exp_nonce(32'h1);
        exp_end(3'b010, 32'd0, 32'd4);
        launch(32'hFFFF_FFFE, 32'h1);
        wait_end("t3");

        // T4: hash core never answers -> error 256 cycles into WAIT
        withhold = 1'b1;
        exp_hs(32'h77);
        exp_end(3'b001, 32'd0, 32'd0);
        launch(32'h77, 32'h80);
        @(negedge clk);
        chk("t4_in_wait_busy", 64'(busy), 64'd1);
        cnt = 0;
        while (!error && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("t4_timeout_cycles", 64'(cnt), 64'd256);
        @(negedge clk);
        late_done = 1'b1;
        @(negedge clk);
        late_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_error_held", 64'({found, exhausted, error, busy}), 64'b0010);
        withhold = 1'b0;
        pass_en = 1'b1; pass_nonce = 32'h100;
        exp_nonce(32'h100);
        exp_end(3'b100, 32'h100, 32'd1);
        launch(32'h100, 32'h105);
        wait_end("t4_relaunch");

        // T5: abort coincident with hash_done of the second nonce
        pass_en = 1'b0;
        exp_nonce(32'h40); exp_hs(32'h41);
        exp_end(3'b000, 32'd0, 32'd1);
        launch(32'h40, 32'h50);
        @(negedge clk);
        wait_hs("t5");
        repeat (DONE_DLY) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_end("t5");
        repeat (4) @(negedge clk);
        chk("t5_idle_outputs", 64'({busy, found, exhausted, error, hif.check_hash}), 64'd0);
        chk("t5_attempts_held", 64'(attempts), 64'd1);
        chk("t5_nonce_held", 64'(hif.nonce), 64'h41);

        // T6: asynchronous reset during CHECK, then single-nonce sweep
        exp_nonce(32'h30);
        launch(32'h30, 32'h35);
        cnt = 0;
        while (!hif.check_hash && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("t6_reached_check", 64'(hif.check_hash), 64'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_async_flags", 64'({busy, found, exhausted, error, hif.hash_start, hif.check_hash}), 64'd0);
        chk("t6_async_nonce", 64'(hif.nonce), 64'd0);
        chk("t6_async_attempts", 64'(attempts), 64'd0);
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        pass_en = 1'b1; pass_nonce = 32'h20;
        exp_nonce(32'h20);
        exp_end(3'b100, 32'h20, 32'd1);
        launch(32'h20, 32'h20);
        wait_end("t6");

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
